// File: rtl/sram_arb_pkg.sv
// Shared constants and helpers for the SRAM port arbiter: index widths,
// packed-bus slot extraction and one-hot encoding.
package sram_arb_pkg;

    localparam int DEF_BURST_MAX  = 16;
    localparam int DEF_RD_LATENCY = 1;

    // Packed slot buses are widened to this size before extraction (8 slots x 32 bits max).
    localparam int SLOT_BUS_W = 256;
    localparam int SLOT_W     = 32;

    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w = w + 1;
        return w;
    endfunction

    function automatic logic [SLOT_W-1:0] slot_get(input logic [SLOT_BUS_W-1:0] bus,
                                                   input int idx, input int w);
        logic [SLOT_BUS_W-1:0] shifted;
        logic [SLOT_W-1:0]     mask;
        shifted = bus >> (idx * w);
        mask    = (SLOT_W'(1) << w) - SLOT_W'(1);
        return shifted[SLOT_W-1:0] & mask;
    endfunction

    function automatic int onehot_index(input logic [7:0] v);
        int idx;
        idx = 0;
        for (int i = 0; i < 8; i++) if (v[i]) idx = i;
        return idx;
    endfunction

endpackage

// File: rtl/arb_rr_picker.sv
// Combinational round-robin picker with optional strict priority for requester 0.
module arb_rr_picker
    import sram_arb_pkg::*;
#(
    parameter int NR = 3,
    parameter int IW = 2
)(
    input  logic [NR-1:0] req,
    input  logic [IW-1:0] last_owner,
    input  logic [NR-1:0] exclude,
    input  logic          hi_prio_en,
    output logic [NR-1:0] pick,
    output logic          valid
);

    logic [NR-1:0] cand;
    logic          found;
    int            idx;

    always_comb begin
        // NOTE: every output and temporary gets a default first so no path infers a latch.
        cand  = req & ~exclude;
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        valid = |cand;
        if (hi_prio_en && cand[0]) begin
            pick[0] = 1'b1;
        end else begin
            for (int k = 1; k <= NR; k++) begin
                idx = (int'(last_owner) + k) % NR;
                for (int j = 0; j < NR; j++) begin
                    if (!found && j == idx && cand[j]) begin
                        pick[j] = 1'b1;
                        found   = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one SRAM read port and one write port among NR requesters with
// round-robin ownership, a burst cap and latency-aligned read-valid strobes.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int AW         = 18,
    parameter int DW         = 16,
    parameter int NR         = 3,
    parameter int BURST_MAX  = DEF_BURST_MAX,
    parameter int RD_LATENCY = DEF_RD_LATENCY,
    parameter int HI_PRIO_EN = 1
)(
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NR-1:0]          req,
    input  logic [NR-1:0]          req_rd_en,
    input  logic [NR*AW-1:0]       req_raddr,
    input  logic [NR-1:0]          req_wr_en,
    input  logic [NR*AW-1:0]       req_waddr,
    input  logic [NR*DW-1:0]       req_wdata,
    output logic [NR-1:0]          grant,
    output logic [clog2(NR)-1:0]   owner_id,
    output logic [NR-1:0]          rvalid,
    output logic [DW-1:0]          rdata,
    output logic [AW-1:0]          sram_raddr,
    input  logic [DW-1:0]          sram_rdata,
    output logic [AW-1:0]          sram_waddr,
    output logic [DW-1:0]          sram_wdata,
    output logic                   sram_wr_enable
);

    localparam int IW = clog2(NR);
    localparam int CW = clog2(BURST_MAX);

    logic [NR-1:0] active, others, exclude, pick, grant_next;
    logic          pick_valid, owner_active, at_cap, arb_point;
    logic [IW-1:0] last_owner, pick_idx;
    logic [CW-1:0] burst_cnt;
    logic [NR-1:0] rd_pipe [RD_LATENCY];

    assign active       = grant & req;
    assign owner_active = |active;
    assign others       = req & ~grant;
    assign at_cap       = (burst_cnt == CW'(BURST_MAX - 1));
    // Covers: no owner, owner released, or owner hit its burst cap with someone waiting.
    assign arb_point    = !owner_active || (at_cap && |others);
    assign exclude      = (owner_active && at_cap) ? grant : '0;
    assign grant_next   = arb_point ? (pick_valid ? pick : '0) : grant;
    assign owner_id     = IW'(onehot_index(8'(grant)));
    assign pick_idx     = IW'(onehot_index(8'(grant_next)));
    assign rvalid       = rd_pipe[RD_LATENCY-1];
    assign rdata        = sram_rdata;

    arb_rr_picker #(.NR(NR), .IW(IW)) u_picker (
        .req        (req),
        .last_owner (last_owner),
        .exclude    (exclude),
        .hi_prio_en (HI_PRIO_EN != 0),
        .pick       (pick),
        .valid      (pick_valid)
    );

    always_comb begin
        sram_raddr     = '0;
        sram_waddr     = '0;
        sram_wdata     = '0;
        sram_wr_enable = 1'b0;
        if (owner_active) begin
            sram_raddr     = AW'(slot_get(SLOT_BUS_W'(req_raddr), int'(owner_id), AW));
            sram_waddr     = AW'(slot_get(SLOT_BUS_W'(req_waddr), int'(owner_id), AW));
            sram_wdata     = DW'(slot_get(SLOT_BUS_W'(req_wdata), int'(owner_id), DW));
            sram_wr_enable = req_wr_en[owner_id];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            grant      <= '0;
            burst_cnt  <= '0;
            last_owner <= IW'(NR - 1);
        end else begin
            grant <= grant_next;
            if (grant_next != grant) begin
                burst_cnt <= '0;
                if (|grant_next) last_owner <= pick_idx;
            end else if (owner_active && !at_cap) begin
                burst_cnt <= burst_cnt + CW'(1);
            end
        end
    end

    // NOTE: the return pipeline is reset, unlike plain storage, so in-flight reads never pulse after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < RD_LATENCY; s++) rd_pipe[s] <= '0;
        end else begin
            rd_pipe[0] <= active & req_rd_en;
            for (int s = 1; s < RD_LATENCY; s++) rd_pipe[s] <= rd_pipe[s-1];
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// cycle-level ownership model of the arbiter.
`timescale 1ns/1ps
module tb_sram_port_arbiter;
    import sram_arb_pkg::*;

    localparam int AW  = 18;
    localparam int DW  = 16;
    localparam int NR  = 3;
    localparam int BM  = 16;
    localparam int LAT = 2;
    localparam int IW  = clog2(NR);

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NR-1:0]     req = '0, req_rd_en = '0, req_wr_en = '0;
    logic [NR*AW-1:0]  req_raddr = '0, req_waddr = '0;
    logic [NR*DW-1:0]  req_wdata = '0;
    logic [NR-1:0]     grant, rvalid;
    logic [IW-1:0]     owner_id;
    logic [DW-1:0]     rdata, sram_rdata, sram_wdata;
    logic [AW-1:0]     sram_raddr, sram_waddr;
    logic              sram_wr_enable;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sram_port_arbiter #(
        .AW(AW), .DW(DW), .NR(NR), .BURST_MAX(BM), .RD_LATENCY(LAT), .HI_PRIO_EN(1)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .req_rd_en(req_rd_en), .req_raddr(req_raddr),
        .req_wr_en(req_wr_en), .req_waddr(req_waddr), .req_wdata(req_wdata),
        .grant(grant), .owner_id(owner_id), .rvalid(rvalid), .rdata(rdata),
        .sram_raddr(sram_raddr), .sram_rdata(sram_rdata), .sram_waddr(sram_waddr),
        .sram_wdata(sram_wdata), .sram_wr_enable(sram_wr_enable)
    );

    // SRAM model: word content is a fixed function of the address, returned LAT cycles later.
    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return DW'(a * 7) ^ DW'(a >> 3) ^ 16'h5A3C;
    endfunction

    logic [AW-1:0] addr_pipe [LAT];
    always @(posedge clk) begin
        addr_pipe[0] <= sram_raddr;
        for (int s = 1; s < LAT; s++) addr_pipe[s] <= addr_pipe[s-1];
    end
    assign sram_rdata = mem_word(addr_pipe[LAT-1]);

    function automatic logic [AW-1:0] slot_a(input logic [NR*AW-1:0] bus, input int i);
        return bus[i*AW +: AW];
    endfunction
    function automatic logic [DW-1:0] slot_d(input logic [NR*DW-1:0] bus, input int i);
        return bus[i*DW +: DW];
    endfunction

    // Reference model: owner index (-1 idle), cycles served, last owner, pending read returns.
    typedef struct { int due; int idx; logic [DW-1:0] data; } rd_ret_t;
    rd_ret_t m_ret[$];
    int m_owner = -1, m_last = NR - 1, m_served = 0, m_next = -1, cyc = 0;
    bit m_act, m_others, m_cap;

    function automatic int model_pick(input logic [NR-1:0] r, input int excl, input int last);
        if (r[0] && excl != 0) return 0;
        for (int k = 1; k <= NR; k++) begin
            int i;
            i = (last + k) % NR;
            if (r[i] && i != excl) return i;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_owner = -1; m_last = NR - 1; m_served = 0;
            m_ret.delete();
        end else begin
            m_act = (m_owner >= 0) && req[m_owner];
            if (m_act && req_rd_en[m_owner])
                m_ret.push_back('{cyc + LAT, m_owner, mem_word(slot_a(req_raddr, m_owner))});
            m_others = (m_owner < 0) ? (req != '0) : ((req & ~(NR'(1) << m_owner)) != '0);
            m_cap    = m_act && (m_served >= BM - 1) && m_others;
            if (!m_act || m_cap) m_next = model_pick(req, m_cap ? m_owner : -1, m_last);
            else                 m_next = m_owner;
            if (m_next != m_owner) begin
                m_served = 0;
                if (m_next >= 0) m_last = m_next;
                m_owner = m_next;
            end else if (m_act) begin
                m_served++;
            end
        end
        while (m_ret.size() > 0 && m_ret[0].due <= cyc) void'(m_ret.pop_front());
        cyc++;
    end

    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    task automatic idle_inputs();
        req = '0; req_rd_en = '0; req_wr_en = '0;
        req_raddr = '0; req_waddr = '0; req_wdata = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req = '1; req_wr_en = '1; req_rd_en = '1;
        req_raddr = '1; req_waddr = '1; req_wdata = '1;
        repeat (3) next_cycle();
        @(negedge clk);
        checks++;
        if ({grant, owner_id, rvalid, sram_wr_enable} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl grant=%b owner_id=%0d rvalid=%b wr_en=%b expected all 0",
                     grant, owner_id, rvalid, sram_wr_enable);
        end
        checks++;
        if ({sram_raddr, sram_waddr, sram_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_sram raddr=%h waddr=%h wdata=%h expected 0",
                     sram_raddr, sram_waddr, sram_wdata);
        end
        next_cycle();
        reset = 1'b0;
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_first_grant_write();
        next_cycle();
        req = 3'b010; req_wr_en = 3'b111;
        req_waddr = {18'h3FFFF, 18'h00100, 18'h2AAAA};
        req_wdata = {16'h1111, 16'hABCD, 16'h2222};
        @(negedge clk);
        checks++;
        if ({grant, sram_wr_enable, sram_waddr, sram_wdata} !== '0) begin
            errors++;
            $display("FAIL pre_grant grant=%b wr_en=%b waddr=%h wdata=%h expected 0",
                     grant, sram_wr_enable, sram_waddr, sram_wdata);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (grant !== 3'b010 || owner_id !== 2'd1 || sram_wr_enable !== 1'b1 ||
            sram_waddr !== 18'h00100 || sram_wdata !== 16'hABCD) begin
            errors++;
            $display("FAIL first_write grant=%b id=%0d wr_en=%b waddr=%h wdata=%h expected 010 1 1 00100 abcd",
                     grant, owner_id, sram_wr_enable, sram_waddr, sram_wdata);
        end
        next_cycle(); idle_inputs();
        next_cycle();
    endtask

    task automatic test_burst_alternation();
        logic [NR-1:0] exp;
        next_cycle();
        req = 3'b110;
        for (int seg = 0; seg < 3; seg++) begin
            exp = (seg % 2 == 0) ? 3'b100 : 3'b010;
            for (int k = 0; k < BM; k++) begin
                next_cycle();
                @(negedge clk);
                checks++;
                if (grant !== exp) begin
                    errors++;
                    $display("FAIL burst_alt seg=%0d k=%0d grant=%b expected %b", seg, k, grant, exp);
                end
            end
        end
        next_cycle(); idle_inputs();
        next_cycle();
    endtask

    task automatic test_hi_prio();
        next_cycle();
        req = 3'b100;
        next_cycle();
        req = 3'b111;
        for (int k = 0; k < BM; k++) begin
            @(negedge clk);
            checks++;
            if (grant !== 3'b100) begin
                errors++;
                $display("FAIL hi_prio_hold k=%0d grant=%b expected 100", k, grant);
            end
            next_cycle();
        end
        @(negedge clk);
        checks++;
        if (grant !== 3'b001) begin
            errors++;
            $display("FAIL hi_prio_win grant=%b expected 001", grant);
        end
        next_cycle(); idle_inputs();
        next_cycle();
    endtask

    task automatic test_read_latency();
        next_cycle();
        req = 3'b110; req_rd_en = 3'b010;
        req_raddr = {18'h0ABCD, 18'h1C200, 18'h01234};
        @(negedge clk);
        checks++;
        if (grant !== 3'b000 || rvalid !== 3'b000) begin
            errors++;
            $display("FAIL rd_setup grant=%b rvalid=%b expected 000 000", grant, rvalid);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (grant !== 3'b010 || sram_raddr !== 18'h1C200) begin
            errors++;
            $display("FAIL rd_issue grant=%b raddr=%h expected 010 1c200", grant, sram_raddr);
        end
        next_cycle();
        req = 3'b100; req_rd_en = '0;
        @(negedge clk);
        checks++;
        if (rvalid !== 3'b000 || sram_raddr !== '0) begin
            errors++;
            $display("FAIL rd_gap rvalid=%b raddr=%h expected 000 0", rvalid, sram_raddr);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (rvalid !== 3'b010 || rdata !== mem_word(18'h1C200) || grant !== 3'b100) begin
            errors++;
            $display("FAIL rd_return rvalid=%b rdata=%h grant=%b expected 010 %h 100",
                     rvalid, rdata, grant, mem_word(18'h1C200));
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (rvalid !== 3'b000) begin
            errors++;
            $display("FAIL rd_single rvalid=%b expected 000", rvalid);
        end
        idle_inputs();
        next_cycle();
        next_cycle();
    endtask

    task automatic test_reset_midop();
        req = 3'b100;
        next_cycle();
        req_rd_en = 3'b100; req_raddr = {18'h2F0F0, 18'h0, 18'h0};
        @(negedge clk);
        checks++;
        if (grant !== 3'b100) begin
            errors++;
            $display("FAIL midop_owner grant=%b expected 100", grant);
        end
        next_cycle();
        reset = 1'b1; req_rd_en = '0;
        next_cycle();
        reset = 1'b0; req = 3'b111;
        @(negedge clk);
        checks++;
        if (grant !== 3'b000 || rvalid !== 3'b000) begin
            errors++;
            $display("FAIL midop_reset grant=%b rvalid=%b expected 000 000", grant, rvalid);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (grant !== 3'b001 || rvalid !== 3'b000) begin
            errors++;
            $display("FAIL midop_after grant=%b rvalid=%b expected 001 000", grant, rvalid);
        end
    endtask

    task automatic test_all_drop();
        next_cycle();
        req = 3'b111; req_wr_en = 3'b111; req_rd_en = 3'b111;
        req_raddr = {18'h33333, 18'h22222, 18'h11111};
        req_waddr = {18'h36666, 18'h25555, 18'h14444};
        req_wdata = {16'h9999, 16'h8888, 16'h7777};
        @(negedge clk);
        checks++;
        if (grant !== 3'b001 || sram_wr_enable !== 1'b1 || sram_waddr !== 18'h14444) begin
            errors++;
            $display("FAIL drop_before grant=%b wr_en=%b waddr=%h expected 001 1 14444",
                     grant, sram_wr_enable, sram_waddr);
        end
        next_cycle();
        req = '0;
        @(negedge clk);
        checks++;
        if (sram_wr_enable !== 1'b0 || {sram_raddr, sram_waddr, sram_wdata} !== '0) begin
            errors++;
            $display("FAIL drop_same wr_en=%b raddr=%h waddr=%h wdata=%h expected all 0",
                     sram_wr_enable, sram_raddr, sram_waddr, sram_wdata);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (grant !== '0 || owner_id !== '0 || sram_wr_enable !== 1'b0 ||
            {sram_raddr, sram_waddr, sram_wdata} !== '0) begin
            errors++;
            $display("FAIL drop_after grant=%b id=%0d wr_en=%b raddr=%h waddr=%h wdata=%h expected all 0",
                     grant, owner_id, sram_wr_enable, sram_raddr, sram_waddr, sram_wdata);
        end
        checks++;
        if (rvalid !== 3'b001 || rdata !== mem_word(18'h11111)) begin
            errors++;
            $display("FAIL drop_rdret rvalid=%b rdata=%h expected 001 %h",
                     rvalid, rdata, mem_word(18'h11111));
        end
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_random(input int n);
        logic [NR-1:0] exp_grant, exp_rv;
        logic [AW-1:0] exp_raddr, exp_waddr;
        logic [DW-1:0] exp_wdata, exp_rdata;
        logic          exp_wen;
        int            exp_id;
        bit            act;
        for (int c = 0; c < n; c++) begin
            next_cycle();
            reset = ($urandom_range(0, 199) == 0);
            for (int i = 0; i < NR; i++) if ($urandom_range(0, 9) == 0) req[i] = ~req[i];
            req_rd_en = NR'($urandom());
            req_wr_en = NR'($urandom());
            req_raddr = (NR*AW)'({$urandom(), $urandom()});
            req_waddr = (NR*AW)'({$urandom(), $urandom()});
            req_wdata = (NR*DW)'({$urandom(), $urandom()});
            @(negedge clk);
            act       = (m_owner >= 0) && req[m_owner];
            exp_grant = (m_owner < 0) ? '0 : (NR'(1) << m_owner);
            exp_id    = (m_owner < 0) ? 0 : m_owner;
            exp_raddr = act ? slot_a(req_raddr, m_owner) : '0;
            exp_waddr = act ? slot_a(req_waddr, m_owner) : '0;
            exp_wdata = act ? slot_d(req_wdata, m_owner) : '0;
            exp_wen   = act ? req_wr_en[m_owner] : 1'b0;
            exp_rv    = '0;
            exp_rdata = '0;
            foreach (m_ret[k]) if (m_ret[k].due == cyc) begin
                exp_rv[m_ret[k].idx] = 1'b1;
                exp_rdata = m_ret[k].data;
            end
            checks++;
            if (grant !== exp_grant || owner_id !== IW'(exp_id)) begin
                errors++;
                $display("FAIL rand_grant cyc=%0d grant=%b id=%0d expected %b %0d",
                         cyc, grant, owner_id, exp_grant, exp_id);
            end
            checks++;
            if (sram_raddr !== exp_raddr || sram_waddr !== exp_waddr ||
                sram_wdata !== exp_wdata || sram_wr_enable !== exp_wen) begin
                errors++;
                $display("FAIL rand_sram cyc=%0d raddr=%h waddr=%h wdata=%h wen=%b expected %h %h %h %b",
                         cyc, sram_raddr, sram_waddr, sram_wdata, sram_wr_enable,
                         exp_raddr, exp_waddr, exp_wdata, exp_wen);
            end
            checks++;
            if (rvalid !== exp_rv || (exp_rv != '0 && rdata !== exp_rdata)) begin
                errors++;
                $display("FAIL rand_rvalid cyc=%0d rvalid=%b rdata=%h expected %b %h",
                         cyc, rvalid, rdata, exp_rv, exp_rdata);
            end
        end
        next_cycle();
        reset = 1'b0;
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_first_grant_write();
        test_burst_alternation();
        test_hi_prio();
        test_read_latency();
        test_reset_midop();
        test_all_drop();
        test_random(2000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
